cond_logic: RTL and testbench
=============================

COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 Parameter: CNT_W, default 16, width of taken-branch counter.
REQ-002 Parameter: FLAG_W, default 4, flag vector width {N,Z,C,V}; fixed at 4, other values unsupported.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; asynchronous and active-high.
REQ-005 flags_i  in  4  ALU flags {N,Z,C,V} of instruction in EX.
REQ-006 cond_i  in  4  condition code of instruction in EX.
REQ-007 flag_write_i  in  2  [1] updates N,Z; [0] updates C,V.
REQ-008 valid_i  in  1  EX holds a real instruction.
REQ-009 stall_i  in  1  EX frozen this cycle; no architectural update.
REQ-010 flush_i  in  1  EX instruction squashed.
REQ-011 reg_write_i, mem_write_i, pc_src_i  in  1 each  unconditioned decoder controls.
REQ-012 reg_write_o, mem_write_o, pc_src_o  out  1 each  condition-gated controls.
REQ-013 cond_ex_o  out  1  condition passed for valid, unflushed instruction.
REQ-014 flags_o  out  4  architectural flag register {N,Z,C,V}.
REQ-015 taken_cnt_o  out  CNT_W  saturating count of committed taken branches.

Function
REQ-016 C follows the ALU convention: carry-out on add, borrow on subtract (10-20 gives C=1; 30-10 gives C=0).
REQ-017 Condition evaluation uses flags_o (pre-update value), never flags_i of the same instruction.
REQ-018 Encoding: 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
REQ-019 Encoding: 1000 HI ~C&~Z; 1001 LS C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 reserved, evaluates 0.
REQ-020 cond_ex_o = valid_i & ~flush_i & cond_pass; combinational, zero latency.
REQ-021 Each gated output = its _i input & cond_ex_o; stall_i does not mask outputs.
REQ-022 Commit condition: cond_ex_o & ~stall_i.
REQ-023 On commit with flag_write_i[1]: N,Z <= flags_i[3:2] at next edge; on commit with flag_write_i[0]: C,V <= flags_i[1:0]; unselected bits hold.
REQ-024 No commit: flags_o holds regardless of flag_write_i.
REQ-025 Back-to-back flag-setting instructions: second evaluates against flags written by first (one-cycle register visibility, no bypass).
REQ-026 taken_cnt_o increments by 1 at edge when pc_src_o & ~stall_i; holds at all-ones (saturation, no wrap).
REQ-027 flush_i and stall_i both high: flush wins for outputs (all gated outputs 0); no state update.
REQ-028 Reserved cond 1111: no outputs, no flag update, no count, no error signalled.

Reset
REQ-029 rst high: flags_o = 0000 and taken_cnt_o = 0 immediately, without waiting for clk.
REQ-030 Combinational outputs during reset follow REQ-020/021 with flags_o = 0000 (EQ fails, NE passes).
REQ-031 Reset deassertion mid-operation: first commit occurs on first rising edge with rst low; no partial update.

Verification
REQ-032 Reset, then cond=1110, valid=1, reg_write_i=1, flag_write=11, flags_i=0100 -> reg_write_o=1 same cycle; flags_o=0100 after edge.
REQ-033 flags_o=0100, cond=0000 EQ, pc_src_i=1 -> pc_src_o=1, taken_cnt_o 0->1; then cond=0001 NE -> pc_src_o=0, count holds at 1.
REQ-034 Subtract 10-20 sets flags_i=1010 with flag_write=11; next instr cond=1011 LT -> pass; cond=0010 CS -> pass; cond=1000 HI -> fail.
REQ-035 flag_write=10 with flags_i=1111 over flags_o=0000 -> flags_o=1100 (C,V unchanged); stall_i=1 on same instr -> flags_o stays 0000.
REQ-036 flush_i=1, cond=1110, all _i=1 -> all gated outputs 0, no flag or count change; preload taken_cnt to FFFF, commit taken branch -> stays FFFF.
REQ-037 Assert rst asynchronously between edges with flags_o=1111, taken_cnt_o=5 -> both 0 before next edge.

Source files
------------

// File: rtl/cond_logic.sv
// cond_logic: condition-code evaluation, control gating, flag register and taken-branch counter
// Ports: flags_i/cond_i/flag_write_i describe the EX instruction; valid_i/stall_i/flush_i qualify it;
// reg_write_i/mem_write_i/pc_src_i are raw decoder controls, the *_o versions are condition-gated;
// cond_ex_o is the qualified condition result, flags_o the architectural {N,Z,C,V},
// taken_cnt_o a saturating count of committed taken branches.
module cond_logic #(
  parameter int CNT_W = 16,
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLAG_W-1:0] flags_i,
  input  logic [3:0]        cond_i,
  input  logic [1:0]        flag_write_i,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              reg_write_i,
  input  logic              mem_write_i,
  input  logic              pc_src_i,
  output logic              reg_write_o,
  output logic              mem_write_o,
  output logic              pc_src_o,
  output logic              cond_ex_o,
  output logic [FLAG_W-1:0] flags_o,
  output logic [CNT_W-1:0]  taken_cnt_o
);
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              n, z, c, v, cond_pass, commit;
  always_comb begin
    {n, z, c, v} = flags_q;
    cond_pass = 1'b0;
    case (cond_i)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = ~c & ~z;
      4'b1001: cond_pass = c | z;
      4'b1010: cond_pass = n == v;
      4'b1011: cond_pass = n != v;
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
    cond_ex_o = valid_i & ~flush_i & cond_pass;
    reg_write_o = reg_write_i & cond_ex_o;
    mem_write_o = mem_write_i & cond_ex_o;
    pc_src_o = pc_src_i & cond_ex_o;
    // a stalled instruction drives its outputs but must not touch state
    commit = cond_ex_o & ~stall_i;
    flags_d[3:2] = (commit & flag_write_i[1]) ? flags_i[3:2] : flags_q[3:2];
    flags_d[1:0] = (commit & flag_write_i[0]) ? flags_i[1:0] : flags_q[1:0];
    cnt_d = (pc_src_o & ~stall_i & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      cnt_q <= '0;
    end else begin
      flags_q <= flags_d;
      cnt_q <= cnt_d;
    end
  end
  assign flags_o = flags_q;
  assign taken_cnt_o = cnt_q;
endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: scoreboard bench for cond_logic against a behavioural flag/counter model
module tb_cond_logic;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] flags_i = '0, cond_i = '0;
  logic [1:0] flag_write_i = '0;
  logic valid_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  logic reg_write_i = 1'b0, mem_write_i = 1'b0, pc_src_i = 1'b0;
  logic reg_write_o, mem_write_o, pc_src_o, cond_ex_o;
  logic [3:0] flags_o;
  logic [15:0] taken_cnt_o;
  cond_logic dut (
    .clk(clk), .rst(rst), .flags_i(flags_i), .cond_i(cond_i), .flag_write_i(flag_write_i),
    .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i), .reg_write_i(reg_write_i),
    .mem_write_i(mem_write_i), .pc_src_i(pc_src_i), .reg_write_o(reg_write_o),
    .mem_write_o(mem_write_o), .pc_src_o(pc_src_o), .cond_ex_o(cond_ex_o),
    .flags_o(flags_o), .taken_cnt_o(taken_cnt_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rw, mw, ps, ce;
    logic [3:0] fl;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int m_cnt = 0;
  logic [3:0] m_flags = '0;
  function automatic bit passes(input logic [3:0] f, input logic [3:0] c);
    bit nn, zz, cc, vv, base;
    {nn, zz, cc, vv} = f;
    if (c == 4'd14) return 1'b1;
    if (c == 4'd15) return 1'b0;
    case (c[3:1])
      3'd0: base = zz;
      3'd1: base = cc;
      3'd2: base = nn;
      3'd3: base = vv;
      3'd4: base = !cc && !zz;
      3'd5: base = nn == vv;
      default: base = !zz && nn == vv;
    endcase
    return base ^ c[0];
  endfunction
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("reg_write_o", 16'(reg_write_o), 16'(e.rw));
      chk("mem_write_o", 16'(mem_write_o), 16'(e.mw));
      chk("pc_src_o", 16'(pc_src_o), 16'(e.ps));
      chk("cond_ex_o", 16'(cond_ex_o), 16'(e.ce));
      chk("flags_o", 16'(flags_o), 16'(e.fl));
      chk("taken_cnt_o", taken_cnt_o, e.cnt);
    end
  end
  task automatic drive(input bit r, input bit mid_rst, input logic [3:0] fl, input logic [3:0] c,
                       input logic [1:0] fw, input bit v, input bit st, input bit fu,
                       input bit rw, input bit mw, input bit ps);
    exp_t e;
    bit ce;
    @(posedge clk);
    #1;
    rst = r; flags_i = fl; cond_i = c; flag_write_i = fw; valid_i = v; stall_i = st;
    flush_i = fu; reg_write_i = rw; mem_write_i = mw; pc_src_i = ps;
    if (mid_rst) begin
      #1 rst = 1'b1;
    end
    if (rst) begin
      m_flags = '0;
      m_cnt = 0;
    end
    ce = v && !fu && passes(m_flags, c);
    e.ce = ce; e.rw = rw && ce; e.mw = mw && ce; e.ps = ps && ce;
    e.fl = m_flags; e.cnt = 16'(m_cnt);
    q.push_back(e);
    if (!rst && ce && !st) begin
      if (fw[1]) m_flags[3:2] = fl[3:2];
      if (fw[0]) m_flags[1:0] = fl[1:0];
      if (ps && m_cnt < 65535) m_cnt++;
    end
  endtask
  initial begin
    drive(1, 0, 4'h0, 4'b0001, 2'b00, 1, 0, 0, 1, 1, 1);
    drive(1, 0, 4'h0, 4'b0000, 2'b00, 1, 0, 0, 1, 1, 1);
    drive(0, 0, 4'b0100, 4'b1110, 2'b11, 1, 0, 0, 1, 0, 0);
    drive(0, 0, 4'h0, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 4'h0, 4'b0001, 2'b00, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 4'b1010, 4'b1110, 2'b11, 1, 0, 0, 1, 0, 0);
    drive(0, 0, 4'h0, 4'b1011, 2'b00, 1, 0, 0, 1, 0, 1);
    drive(0, 0, 4'h0, 4'b0010, 2'b00, 1, 0, 0, 1, 0, 1);
    drive(0, 0, 4'h0, 4'b1000, 2'b00, 1, 0, 0, 1, 0, 1);
    drive(0, 0, 4'h0, 4'b1111, 2'b11, 1, 0, 0, 1, 1, 1);
    drive(1, 0, 4'h0, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 4'b1111, 4'b1110, 2'b10, 1, 1, 0, 1, 1, 0);
    drive(0, 0, 4'b1111, 4'b1110, 2'b10, 1, 0, 0, 1, 1, 0);
    drive(0, 0, 4'b0000, 4'b1110, 2'b11, 1, 1, 1, 1, 1, 1);
    drive(0, 0, 4'b1111, 4'b1110, 2'b11, 1, 0, 1, 1, 1, 1);
    drive(0, 0, 4'b1111, 4'b1110, 2'b11, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 4'h0, 4'b1110, 2'b00, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 4'h0, 4'b1110, 2'b00, 1, 1, 0, 0, 0, 1);
    drive(0, 0, 4'h0, 4'b0011, 2'b00, 1, 0, 0, 0, 0, 1);
    drive(0, 1, 4'h0, 4'b1110, 2'b00, 1, 0, 0, 1, 1, 1);
    drive(1, 0, 4'h0, 4'b0001, 2'b11, 1, 0, 0, 1, 1, 1);
    drive(0, 0, 4'b0110, 4'b0000, 2'b11, 1, 0, 0, 1, 0, 1);
    drive(0, 0, 4'b1001, 4'b0000, 2'b11, 1, 0, 0, 1, 0, 1);
    drive(0, 0, 4'b0000, 4'b0000, 2'b11, 1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 49) == 0, 0, 4'($urandom), 4'($urandom), 2'($urandom),
            $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            1'($urandom), 1'($urandom), 1'($urandom));
    drive(1, 0, 4'h0, 4'b1110, 2'b00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) drive(0, 0, 4'h0, 4'b1110, 2'b00, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 4'b0100, 4'b0001, 2'b11, 1, 0, 0, 1, 1, 1);
    drive(0, 0, 4'h0, 4'b0000, 2'b00, 1, 0, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
